pe_anneal_scheduler: RTL

- Sequences a PE_1D array through a bounded number of annealing iterations.
- Per iteration: issues the PE enable, waits for the gradient/Hamiltonian adder-tree latency, then samples the reduced array Hamiltonian.
- Tracks the best (minimum) Hamiltonian seen and pulses a snapshot strobe so external logic can capture the spin phases of the best state.
- Supports early stop on stagnation and a synchronous abort.

---
 rtl/pe_anneal_scheduler_if.sv | 33 +++
 rtl/pe_anneal_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pe_anneal_scheduler_if.sv
// Control/status bundle between the annealing scheduler and its host.
// master = host side (requests, limits, array Hamiltonian); slave = scheduler.
interface pe_anneal_scheduler_if #(
    parameter int H_WIDTH = 22,
    parameter int ITER_W  = 16
) ();
    logic                      start;
    logic                      abort;
    logic [ITER_W-1:0]         iter_limit;
    logic [ITER_W-1:0]         stall_limit;
    logic signed [H_WIDTH-1:0] h_sum;
    logic                      phase_load;
    logic                      pe_ena;
    logic                      snap;
    logic                      busy;
    logic                      done;
    logic                      best_valid;
    logic signed [H_WIDTH-1:0] best_h;
    logic [ITER_W-1:0]         best_iter;
    logic [ITER_W-1:0]         iter_cnt;

    modport master (
        output start, abort, iter_limit, stall_limit, h_sum,
        input  phase_load, pe_ena, snap, busy, done,
               best_valid, best_h, best_iter, iter_cnt
    );

    modport slave (
        input  start, abort, iter_limit, stall_limit, h_sum,
        output phase_load, pe_ena, snap, busy, done,
               best_valid, best_h, best_iter, iter_cnt
    );
endinterface

// File: rtl/pe_anneal_scheduler.sv
// Runs a PE_1D array through bounded annealing iterations, tracking the
// minimum sampled Hamiltonian and strobing snap when a new best is recorded.
module pe_anneal_scheduler #(
    parameter int H_WIDTH       = 22,
    parameter int ITER_W        = 16,
    parameter int SETTLE_CYCLES = 6
) (
    input  logic               clk,
    input  logic               reset,
    pe_anneal_scheduler_if.slave bus
);
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [SW-1:0]             settle_cnt;
    logic [ITER_W-1:0]         lim_q;
    logic [ITER_W-1:0]         stall_lim_q;
    logic [ITER_W-1:0]         stall_cnt;
    logic [ITER_W-1:0]         iter_cnt_q;
    logic [ITER_W-1:0]         best_iter_q;
    logic signed [H_WIDTH-1:0] best_h_q;
    logic                      best_valid_q;

    logic phase_load_q, pe_ena_q, snap_q;
    logic phase_load_d, pe_ena_d, snap_d;

    logic              busy_state;
    logic              start_ok;
    logic              sample_commit;
    logic              improve;
    logic              last_iter;
    logic              stall_hit;
    logic [ITER_W-1:0] stall_next;
    logic [ITER_W-1:0] iter_next;

    always_comb begin
        busy_state    = (state == S_LOAD) || (state == S_RUN) ||
                        (state == S_SETTLE) || (state == S_SAMPLE);
        start_ok      = bus.start && ((state == S_IDLE) || (state == S_DONE));
        sample_commit = (state == S_SAMPLE) && !bus.abort;
        improve       = !best_valid_q || (bus.h_sum < best_h_q);
        if (improve)
            stall_next = '0;
        else if (&stall_cnt)
            stall_next = stall_cnt;
        else
            stall_next = stall_cnt + ITER_W'(1);
        iter_next     = iter_cnt_q + ITER_W'(1);
        last_iter     = (iter_next == lim_q);
        stall_hit     = (stall_lim_q != '0) && (stall_next == stall_lim_q);
    end

    // State register; control strobes are registered from the next-state decode
    // so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            phase_load_q <= 1'b0;
            pe_ena_q     <= 1'b0;
            snap_q       <= 1'b0;
        end else begin
            state        <= next_state;
            phase_load_q <= phase_load_d;
            pe_ena_q     <= pe_ena_d;
            snap_q       <= snap_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start)
                    next_state = S_LOAD;
            end
            S_LOAD: begin
                next_state = (lim_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == '0)
                    next_state = S_SAMPLE;
            end
            S_SAMPLE: begin
                next_state = (last_iter || stall_hit) ? S_DONE : S_RUN;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (bus.abort && busy_state)
            next_state = S_IDLE;
    end

    always_comb begin
        phase_load_d = (next_state == S_LOAD);
        pe_ena_d     = (next_state == S_RUN);
        snap_d       = sample_commit && improve;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt   <= '0;
            lim_q        <= '0;
            stall_lim_q  <= '0;
            stall_cnt    <= '0;
            iter_cnt_q   <= '0;
            best_iter_q  <= '0;
            best_h_q     <= '0;
            best_valid_q <= 1'b0;
        end else begin
            if (start_ok) begin
                lim_q        <= bus.iter_limit;
                stall_lim_q  <= bus.stall_limit;
                stall_cnt    <= '0;
                iter_cnt_q   <= '0;
                best_iter_q  <= '0;
                best_h_q     <= '0;
                best_valid_q <= 1'b0;
            end

            if (state == S_RUN)
                settle_cnt <= SW'(SETTLE_CYCLES - 1);
            else if ((state == S_SETTLE) && (settle_cnt != '0))
                settle_cnt <= settle_cnt - SW'(1);

            if (sample_commit) begin
                iter_cnt_q <= iter_next;
                stall_cnt  <= stall_next;
                if (improve) begin
                    best_h_q     <= bus.h_sum;
                    best_iter_q  <= iter_cnt_q;
                    best_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.phase_load = phase_load_q;
    assign bus.pe_ena     = pe_ena_q;
    assign bus.snap       = snap_q;
    assign bus.busy       = busy_state;
    assign bus.done       = (state == S_DONE);
    assign bus.best_valid = best_valid_q;
    assign bus.best_h     = best_h_q;
    assign bus.best_iter  = best_iter_q;
    assign bus.iter_cnt   = iter_cnt_q;
endmodule
